// File: rtl/rx_serial_7e1_uc_pkg.sv
// Shared definitions for the 7E1 serial receiver control unit.
//   estado_t             : FSM state encodings, also exported on db_estado
//   FRAME_LEN            : bits per frame (start + 7 data + parity + stop)
//   CLKS_PER_BIT_DEFAULT : 50 MHz / 115200 baud
package rx_serial_7e1_uc_pkg;

   typedef enum logic [3:0] {
      INICIAL    = 4'd0,
      PREPARACAO = 4'd1,
      ESPERA     = 4'd2,
      AMOSTRA    = 4'd3,
      VERIFICA   = 4'd4,
      FINAL      = 4'd5
   } estado_t;

   localparam int unsigned FRAME_LEN            = 10;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/rx_serial_7e1_uc_baud_timer.sv
// Loadable down-counter that times mid-bit sampling.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-low
//   carga_meio : load half-bit interval (start bit -> first sample)
//   carga_bit  : load full-bit interval (sample -> next sample)
//   tick       : one-cycle pulse in the last cycle of the loaded interval
module rx_serial_baud_timer
   import rx_serial_7e1_uc_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic carga_meio,
   input  logic carga_bit,
   output logic tick
);

   localparam int unsigned W = $clog2(CLKS_PER_BIT);

   // The load cycle and the cycle after tick both belong to the interval,
   // hence the -2 on each reload value.
   localparam logic [W-1:0] MEIO = W'(CLKS_PER_BIT / 2 - 2);
   localparam logic [W-1:0] BIT  = W'(CLKS_PER_BIT - 2);

   logic [W-1:0] cnt_q, cnt_d;
   logic         armed_q, armed_d;

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (carga_meio) begin
         cnt_d   = MEIO;
         armed_d = 1'b1;
      end else if (carga_bit) begin
         cnt_d   = BIT;
         armed_d = 1'b1;
      end else if (armed_q) begin
         // Disarm at zero instead of wrapping; only a reload re-arms.
         if (cnt_q == '0) armed_d = 1'b0;
         else             cnt_d   = cnt_q - 1'b1;
      end
   end

   assign tick = armed_q && (cnt_q == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/rx_serial_7e1_uc.sv
// Control unit of the 7E1 asynchronous serial receiver.
//   clock, reset      : system clock (rising edge), async active-low reset
//   RX                : raw serial line, idle high
//   fim, par_ok       : datapath bit counter at 9, datapath even parity ok
//   zera, conta       : clear / increment datapath bit counter
//   carrega, desloca  : preload shifter with all ones / shift RX in at MSB
//   registra          : load the 7-bit output register
//   pronto            : one-cycle frame-complete pulse
//   erro_paridade     : sticky parity error of last frame
//   erro_parada       : sticky stop-bit error of last frame
//   db_estado         : current state encoding
module rx_serial_7e1_uc
   import rx_serial_7e1_uc_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       RX,
   input  logic       fim,
   input  logic       par_ok,
   output logic       zera,
   output logic       conta,
   output logic       carrega,
   output logic       desloca,
   output logic       registra,
   output logic       pronto,
   output logic       erro_paridade,
   output logic       erro_parada,
   output logic [3:0] db_estado
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rx_s;

   estado_t state_q, state_d;
   logic    primeira_q, primeira_d;  // next AMOSTRA is the start-bit sample
   logic    stop_ok_q, stop_ok_d;
   logic    erro_paridade_q, erro_paridade_d;
   logic    erro_parada_q, erro_parada_d;
   logic    carga_meio, carga_bit, tick;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], RX};
   assign rx_s   = sync_q[SYNC_STAGES-1];

   rx_serial_baud_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_timer (
      .clock      (clock),
      .reset      (reset),
      .carga_meio (carga_meio),
      .carga_bit  (carga_bit),
      .tick       (tick)
   );

   always_comb begin
      state_d         = state_q;
      primeira_d      = primeira_q;
      stop_ok_d       = stop_ok_q;
      erro_paridade_d = erro_paridade_q;
      erro_parada_d   = erro_parada_q;
      carga_meio      = 1'b0;
      carga_bit       = 1'b0;
      zera            = 1'b0;
      conta           = 1'b0;
      carrega         = 1'b0;
      desloca         = 1'b0;
      registra        = 1'b0;
      pronto          = 1'b0;
      case (state_q)
         INICIAL: begin
            if (!rx_s) state_d = PREPARACAO;
         end
         PREPARACAO: begin
            carrega         = 1'b1;
            zera            = 1'b1;
            carga_meio      = 1'b1;
            erro_paridade_d = 1'b0;
            erro_parada_d   = 1'b0;
            primeira_d      = 1'b1;
            state_d         = ESPERA;
         end
         ESPERA: begin
            if (tick) state_d = AMOSTRA;
         end
         AMOSTRA: begin
            desloca    = 1'b1;
            conta      = 1'b1;
            primeira_d = 1'b0;
            if (primeira_q && rx_s) begin
               state_d = INICIAL;
            end else if (fim) begin
               stop_ok_d = rx_s;
               state_d   = VERIFICA;
            end else begin
               carga_bit = 1'b1;
               state_d   = ESPERA;
            end
         end
         VERIFICA: begin
            registra        = 1'b1;
            erro_paridade_d = ~par_ok;
            erro_parada_d   = ~stop_ok_q;
            state_d         = FINAL;
         end
         FINAL: begin
            pronto  = 1'b1;
            state_d = INICIAL;
         end
         default: state_d = INICIAL;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q          <= '1;
         state_q         <= INICIAL;
         primeira_q      <= 1'b0;
         stop_ok_q       <= 1'b0;
         erro_paridade_q <= 1'b0;
         erro_parada_q   <= 1'b0;
      end else begin
         sync_q          <= sync_d;
         state_q         <= state_d;
         primeira_q      <= primeira_d;
         stop_ok_q       <= stop_ok_d;
         erro_paridade_q <= erro_paridade_d;
         erro_parada_q   <= erro_parada_d;
      end
   end

   assign erro_paridade = erro_paridade_q;
   assign erro_parada   = erro_parada_q;
   assign db_estado     = state_q;

endmodule
